// File: rtl/ndp_pkg.sv
// ndp_pkg: shared FSM encodings and data-width constant for the NDP job arbiter
package ndp_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {S_IDLE, S_CRST, S_STREAM, S_WAIT, S_DONE} ndp_state_e;
endpackage

// File: rtl/ndp_rr_pick.sv
// ndp_rr_pick: combinational round-robin picker, first request at or after ptr
module ndp_rr_pick #(
  parameter int N  = 4,
  parameter int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          found
);
  logic [PW-1:0] idx;
  // scan N positions starting at ptr, wrapping, and keep the first hit
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ndp_job_arbiter.sv
// ndp_job_arbiter: round-robin job arbiter feeding one NDP core with watchdog
module ndp_job_arbiter
  import ndp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 16,
  parameter int TMO_W   = 20,
  localparam int IW     = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        src_valid,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  output logic [NUM_REQ-1:0]        src_ready,
  output logic                      core_reset,
  output logic                      core_data_in_flag,
  output logic [DATA_W-1:0]         core_data_in,
  input  logic                      core_data_read_flag,
  input  logic                      core_calc_done_flag,
  output logic                      done_valid,
  output logic [IW-1:0]             done_id,
  output logic                      done_err,
  input  logic                      done_ready
);
  ndp_state_e state, next;
  logic [NUM_REQ-1:0] pick;
  logic found;
  logic [IW-1:0] pick_id, gid, ptr;
  logic [LEN_W-1:0] pick_len, remain;
  logic [TMO_W-1:0] wdog, wdog_inc;
  logic err_q, streaming, xfer, last, tmo;

  ndp_rr_pick #(.N(NUM_REQ), .PW(IW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .grant(pick),
    .found(found)
  );

  // encode the one-hot pick into an index
  always_comb begin
    pick_id = '0;
    for (int i = 0; i < NUM_REQ; i++) pick_id = pick[i] ? IW'(i) : pick_id;
  end

  assign pick_len  = req_len[pick_id*LEN_W +: LEN_W];
  assign streaming = state == S_STREAM;
  assign xfer      = streaming & src_valid[gid] & core_data_read_flag;
  assign last      = xfer && remain == LEN_W'(1);
  assign wdog_inc  = wdog + 1'b1;
  assign tmo       = &wdog_inc;

  assign core_reset        = reset | (state == S_CRST);
  assign core_data_in_flag = streaming & src_valid[gid];
  assign core_data_in      = streaming ? src_data[gid*DATA_W +: DATA_W] : '0;
  assign src_ready         = xfer ? NUM_REQ'(1) << gid : '0;
  assign done_valid        = state == S_DONE;
  assign done_id           = done_valid ? gid : '0;
  assign done_err          = done_valid & err_q;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= next;
  end

  // next-state and the one-cycle job accept
  always_comb begin
    next = state;
    req_ready = '0;
    unique case (state)
      S_IDLE: begin
        req_ready = found ? pick : '0;
        next = !found ? S_IDLE : pick_len == '0 ? S_DONE : S_CRST;
      end
      S_CRST:   next = S_STREAM;
      S_STREAM: next = last ? S_WAIT : S_STREAM;
      S_WAIT:   next = (core_calc_done_flag || tmo) ? S_DONE : S_WAIT;
      S_DONE:   next = done_ready ? S_IDLE : S_DONE;
      default:  next = S_IDLE;
    endcase
  end

  // job context: pointer, grant, word count, watchdog and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      gid <= '0;
      remain <= '0;
      wdog <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (found) begin
          gid <= pick_id;
          remain <= pick_len;
          ptr <= pick_id == IW'(NUM_REQ - 1) ? '0 : pick_id + 1'b1;
          err_q <= pick_len == '0;
          wdog <= '0;
        end
        S_STREAM: begin
          remain <= xfer ? remain - 1'b1 : remain;
          wdog <= '0;
        end
        S_WAIT: begin
          wdog <= wdog_inc;
          err_q <= !core_calc_done_flag && tmo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ndp_job_arbiter.sv
// tb_ndp_job_arbiter: directed self-checking bench for the NDP job arbiter
module tb_ndp_job_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid, req_ready, src_valid, src_ready;
  logic [63:0] req_len;
  logic [127:0] src_data;
  logic core_reset, core_data_in_flag, core_data_read_flag, core_calc_done_flag;
  logic [31:0] core_data_in;
  logic done_valid, done_err, done_ready;
  logic [1:0] done_id;
  int checks = 0;
  int errors = 0;

  ndp_job_arbiter #(.NUM_REQ(4), .LEN_W(16), .TMO_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_len(req_len),
    .req_ready(req_ready),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .core_reset(core_reset),
    .core_data_in_flag(core_data_in_flag),
    .core_data_in(core_data_in),
    .core_data_read_flag(core_data_read_flag),
    .core_calc_done_flag(core_calc_done_flag),
    .done_valid(done_valid),
    .done_id(done_id),
    .done_err(done_err),
    .done_ready(done_ready)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    req_len = '0;
    src_valid = '0;
    src_data = '0;
    core_data_read_flag = 1'b0;
    core_calc_done_flag = 1'b0;
    done_ready = 1'b0;
    cyc();
    cyc();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (done_valid !== 1'b0 || done_err !== 1'b0 || done_id !== 2'd0) begin errors++; $display("FAIL reset_done got v%b e%b id%0d exp v0 e0 id0", done_valid, done_err, done_id); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset got %b exp 1", core_reset); end
    checks++; if (core_data_in_flag !== 1'b0 || src_ready !== 4'b0000 || core_data_in !== 32'd0) begin errors++; $display("FAIL reset_stream got f%b r%b d%h exp 0", core_data_in_flag, src_ready, core_data_in); end
    reset = 1'b0;
    #1;
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL release_core_reset got %b exp 0", core_reset); end
    cyc();
  endtask

  task automatic test_single();
    logic [31:0] words [3];
    words[0] = 32'hA0A0_0001;
    words[1] = 32'hB1B1_0002;
    words[2] = 32'hC2C2_0003;
    req_valid = 4'b0100;
    req_len[2*16 +: 16] = 16'd3;
    src_valid = 4'b0100;
    core_data_read_flag = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", req_ready); end
    cyc();
    req_valid = '0;
    checks++; if (core_reset !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL single_crst got cr%b rr%b exp cr1 rr0000", core_reset, req_ready); end
    checks++; if (core_data_in_flag !== 1'b0) begin errors++; $display("FAIL single_crst_flag got %b exp 0", core_data_in_flag); end
    cyc();
    for (int k = 0; k < 3; k++) begin
      src_data[2*32 +: 32] = words[k];
      #1;
      checks++; if (core_reset !== 1'b0 || core_data_in_flag !== 1'b1 || core_data_in !== words[k] || src_ready !== 4'b0100) begin
        errors++; $display("FAIL single_word%0d got cr%b f%b d%h r%b exp cr0 f1 d%h r0100", k, core_reset, core_data_in_flag, core_data_in, src_ready, words[k]);
      end
      cyc();
    end
    checks++; if (core_data_in_flag !== 1'b0 || src_ready !== 4'b0000 || core_data_in !== 32'd0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL single_wait got f%b r%b d%h dv%b exp 0", core_data_in_flag, src_ready, core_data_in, done_valid);
    end
    core_calc_done_flag = 1'b1;
    cyc();
    core_calc_done_flag = 1'b0;
    checks++; if (done_valid !== 1'b1 || done_id !== 2'd2 || done_err !== 1'b0) begin errors++; $display("FAIL single_done got v%b id%0d e%b exp v1 id2 e0", done_valid, done_id, done_err); end
    cyc();
    checks++; if (done_valid !== 1'b1 || done_id !== 2'd2) begin errors++; $display("FAIL single_done_hold got v%b id%0d exp v1 id2", done_valid, done_id); end
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL single_done_clear got %b exp 0", done_valid); end
  endtask

  task automatic test_fairness();
    int n;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req_valid = 4'b1111;
    req_len = {16'd1, 16'd1, 16'd1, 16'd1};
    src_valid = 4'b1111;
    core_data_read_flag = 1'b1;
    core_calc_done_flag = 1'b1;
    done_ready = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (req_ready === 4'b0000 && n < 10) begin cyc(); n++; end
      checks++; if (req_ready !== 4'b0001 << (j % 4)) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", j, req_ready, 4'b0001 << (j % 4)); end
      cyc();
      n = 0;
      while (done_valid !== 1'b1 && n < 10) begin cyc(); n++; end
      checks++; if (done_valid !== 1'b1 || done_id !== 2'(j % 4) || done_err !== 1'b0) begin
        errors++; $display("FAIL fair_done%0d got v%b id%0d e%b exp v1 id%0d e0", j, done_valid, done_id, done_err, j % 4);
      end
      cyc();
    end
    req_valid = '0;
    core_calc_done_flag = 1'b0;
    done_ready = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    int xfers;
    int n;
    req_valid = 4'b1000;
    req_len[3*16 +: 16] = 16'd4;
    src_valid = 4'b1000;
    src_data[3*32 +: 32] = 32'h5555_AAAA;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got %b exp 1000", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    xfers = 0;
    n = 0;
    while (core_data_in_flag === 1'b1 && n < 20) begin
      core_data_read_flag = (n % 2) == 0;
      #1;
      checks++; if (src_ready !== (core_data_read_flag ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL bp_src_ready%0d got %b exp %b", n, src_ready, core_data_read_flag ? 4'b1000 : 4'b0000);
      end
      xfers += src_ready[3] ? 1 : 0;
      cyc();
      n++;
    end
    checks++; if (xfers !== 4 || n !== 7) begin errors++; $display("FAIL bp_count got xfers %0d cycles %0d exp xfers 4 cycles 7", xfers, n); end
    core_data_read_flag = 1'b1;
    core_calc_done_flag = 1'b1;
    cyc();
    core_calc_done_flag = 1'b0;
    checks++; if (done_valid !== 1'b1 || done_id !== 2'd3 || done_err !== 1'b0) begin errors++; $display("FAIL bp_done got v%b id%0d e%b exp v1 id3 e0", done_valid, done_id, done_err); end
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    req_valid = 4'b0010;
    req_len[1*16 +: 16] = 16'd0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_grant got %b exp 0010", req_ready); end
    cyc();
    req_valid = '0;
    checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL zero_core_reset got %b exp 0", core_reset); end
    checks++; if (done_valid !== 1'b1 || done_id !== 2'd1 || done_err !== 1'b1) begin errors++; $display("FAIL zero_done got v%b id%0d e%b exp v1 id1 e1", done_valid, done_id, done_err); end
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;
    checks++; if (done_valid !== 1'b0 || done_err !== 1'b0) begin errors++; $display("FAIL zero_clear got v%b e%b exp v0 e0", done_valid, done_err); end
  endtask

  task automatic test_timeout();
    int early;
    req_valid = 4'b0001;
    req_len[0 +: 16] = 16'd1;
    src_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL tmo_grant got %b exp 0001", req_ready); end
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    checks++; if (core_data_in_flag !== 1'b0 || done_valid !== 1'b0) begin errors++; $display("FAIL tmo_wait_entry got f%b dv%b exp 0 0", core_data_in_flag, done_valid); end
    early = 0;
    for (int k = 1; k < 15; k++) begin
      cyc();
      early += done_valid ? 1 : 0;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early got %0d done cycles exp 0", early); end
    cyc();
    checks++; if (done_valid !== 1'b1 || done_err !== 1'b1 || done_id !== 2'd0) begin errors++; $display("FAIL tmo_done got v%b e%b id%0d exp v1 e1 id0", done_valid, done_err, done_id); end
    done_ready = 1'b1;
    cyc();
    done_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    req_len[2*16 +: 16] = 16'd5;
    src_valid = 4'b0100;
    core_data_read_flag = 1'b1;
    done_ready = 1'b1;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    checks++; if (core_data_in_flag !== 1'b1) begin errors++; $display("FAIL mid_streaming got %b exp 1", core_data_in_flag); end
    reset = 1'b1;
    #1;
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL mid_core_reset got %b exp 1", core_reset); end
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (done_valid !== 1'b0 || core_data_in_flag !== 1'b0 || src_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_idle got dv%b f%b r%b exp 0 0 0000", done_valid, core_data_in_flag, src_ready);
    end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b exp 0001", req_ready); end
    reset = 1'b1;
    req_valid = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
